// File: rtl/serial_paralelo.sv
// Receive-side deserializer: hunts for COM to find byte alignment, trains on
// COM_REQ aligned COMs, then presents each aligned non-COM byte MSB-first.
module serial_paralelo #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] COM     = 8'hBC,
    parameter int              COM_REQ = 4
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             byte_strobe,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam int NW = $clog2(COM_REQ + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] data_nx;
    logic [CW-1:0]    bit_cnt, bit_cnt_nx, bit_cnt_inc;
    logic [NW-1:0]    com_cnt, com_cnt_nx;
    logic             valid_nx, active_nx, strobe_nx;
    logic             boundary, is_com;

    // nxt is the byte whose LSB is being sampled on this edge.
    assign nxt         = {sr[WIDTH-2:0], data_in};
    assign is_com      = (nxt == COM);
    assign boundary    = (bit_cnt == CW'(WIDTH - 1));
    assign bit_cnt_inc = boundary ? '0 : bit_cnt + 1'b1;
    assign state_dbg   = state;

    // Output contract: byte_strobe pulses for one cycle on every aligned byte
    // once active; valid_out qualifies data_out (1 = data byte, 0 = idle COM)
    // and holds until the next strobe. There is no back-pressure.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        com_cnt_nx = com_cnt;
        data_nx    = data_out;
        valid_nx   = valid_out;
        active_nx  = active;
        strobe_nx  = 1'b0;
        case (state)
            SEARCH: begin
                if (is_com) begin
                    bit_cnt_nx = '0;
                    if (COM_REQ <= 1) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end else begin
                        state_nx   = ALIGN;
                        com_cnt_nx = NW'(1);
                    end
                end
            end
            ALIGN: begin
                bit_cnt_nx = bit_cnt_inc;
                if (boundary) begin
                    if (!is_com) begin
                        state_nx   = SEARCH;
                        com_cnt_nx = '0;
                        bit_cnt_nx = '0;
                    end else if ((com_cnt + 1'b1) == NW'(COM_REQ)) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end else begin
                        com_cnt_nx = com_cnt + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nx = bit_cnt_inc;
                if (boundary) begin
                    strobe_nx = 1'b1;
                    if (is_com) begin
                        valid_nx = 1'b0;
                    end else begin
                        data_nx  = nxt;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            com_cnt     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            sr          <= nxt;
            bit_cnt     <= bit_cnt_nx;
            com_cnt     <= com_cnt_nx;
            data_out    <= data_nx;
            valid_out   <= valid_nx;
            active      <= active_nx;
            byte_strobe <= strobe_nx;
        end
    end

endmodule
